multicycle_controller: RTL and testbench

//  Control FSM sequencing the multicycle ARM-subset datapath (ALU, regfile, extend, shared instr/data memory).

---
 rtl/multicycle_controller.sv | 239 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : multicycle_controller                                         |
// | Brief    : Control FSM for the multicycle ARM-subset datapath. Decodes   |
// |            the latched instruction, tracks NZCV flags, evaluates the     |
// |            condition field and drives all mux selects and strobes.       |
// |            Optional feature macro: MCCTRL_CMP_EN (cmd 1010 with S=1 is   |
// |            CMP: SUB that updates flags but never writes a register).     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module multicycle_controller #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [2:0]  ALUControl,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [2:0] c_alu_add = 3'b000;
  localparam logic [2:0] c_alu_sub = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_orr = 3'b011;
  localparam logic [2:0] c_alu_eor = 3'b100;

  state_t      r_state;
  logic [3:0]  r_flags;     // {N,Z,C,V}
  state_t      w_next;

  logic [3:0]  w_cond;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic [3:0]  w_cmd;
  logic        w_s;
  logic        w_rd_pc;
  logic        w_condex;
  logic        w_cmd_def;    // cmd is one of the supported ALU operations
  logic        w_cmd_arith;  // ADD/SUB family: C and V are meaningful
  logic        w_cmd_nowb;   // compare-only: result is discarded
  logic [2:0]  w_exec_alu;
  logic        w_alu_wb;
  logic        w_pcw;
  logic        w_irw;
  logic        w_rw;
  logic        w_mw;
  logic        w_unused;

  assign w_cond   = Instr[31:28];
  assign w_op     = Instr[27:26];
  assign w_funct  = Instr[25:20];
  assign w_cmd    = w_funct[4:1];
  assign w_s      = w_funct[0];
  assign w_rd_pc  = (Instr[15:12] == 4'hF);
  assign w_unused = ^{Instr[19:16], Instr[11:0]};

  assign ImmSrc   = w_op;
  assign RegSrc   = {(w_op == 2'b01), (w_op == 2'b10)};
  assign State    = r_state;

  // Strobes are suppressed while reset is held so nothing is written mid-reset.
  assign PCWrite  = w_pcw & ~reset;
  assign IRWrite  = w_irw & ~reset;
  assign RegWrite = w_rw  & ~reset;
  assign MemWrite = w_mw  & ~reset;

  // Condition-field evaluation against the architectural flags.
  always_comb begin
    w_condex = 1'b0;
    case (w_cond)
      4'b0000: w_condex = r_flags[2];
      4'b0001: w_condex = ~r_flags[2];
      4'b0010: w_condex = r_flags[1];
      4'b0011: w_condex = ~r_flags[1];
      4'b0100: w_condex = r_flags[3];
      4'b0101: w_condex = ~r_flags[3];
      4'b0110: w_condex = r_flags[0];
      4'b0111: w_condex = ~r_flags[0];
      4'b1000: w_condex = r_flags[1] & ~r_flags[2];
      4'b1001: w_condex = ~r_flags[1] | r_flags[2];
      4'b1010: w_condex = (r_flags[3] == r_flags[0]);
      4'b1011: w_condex = (r_flags[3] != r_flags[0]);
      4'b1100: w_condex = ~r_flags[2] & (r_flags[3] == r_flags[0]);
      4'b1101: w_condex = r_flags[2] | (r_flags[3] != r_flags[0]);
      4'b1110: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  // Data-processing command decode; unknown commands execute as a harmless ADD.
  always_comb begin
    w_cmd_def   = 1'b1;
    w_cmd_arith = 1'b0;
    w_cmd_nowb  = 1'b0;
    w_exec_alu  = c_alu_add;
    case (w_cmd)
      4'b0100: begin w_exec_alu = c_alu_add; w_cmd_arith = 1'b1; end
      4'b0010: begin w_exec_alu = c_alu_sub; w_cmd_arith = 1'b1; end
      4'b0000: w_exec_alu = c_alu_and;
      4'b1100: w_exec_alu = c_alu_orr;
      4'b0001: w_exec_alu = c_alu_eor;
`ifdef MCCTRL_CMP_EN
      4'b1010: begin
        if (w_s) begin
          w_exec_alu  = c_alu_sub;
          w_cmd_arith = 1'b1;
          w_cmd_nowb  = 1'b1;
        end else begin
          w_cmd_def   = 1'b0;
        end
      end
`endif
      default: w_cmd_def = 1'b0;
    endcase
  end

  assign w_alu_wb = w_condex & w_cmd_def & ~w_cmd_nowb;

  // Next-state selection, including memory wait-state holds.
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:    w_next = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (w_op)
          2'b00:   w_next = w_funct[5] ? EXECI : EXECR;
          2'b01:   w_next = MEMADR;
          2'b10:   w_next = BRANCH;
          default: w_next = FETCH;
        endcase
      end
      MEMADR:   w_next = w_funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  w_next = MemReady ? MEMWB : MEMREAD;
      MEMWB:    w_next = FETCH;
      MEMWRITE: w_next = (~w_condex | MemReady) ? FETCH : MEMWRITE;
      EXECR:    w_next = ALUWB;
      EXECI:    w_next = ALUWB;
      ALUWB:    w_next = FETCH;
      BRANCH:   w_next = FETCH;
      default:  w_next = FETCH;
    endcase
  end

  // Per-state datapath selects and raw write strobes.
  always_comb begin
    w_pcw      = 1'b0;
    w_irw      = 1'b0;
    w_rw       = 1'b0;
    w_mw       = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = c_alu_add;
    case (r_state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_irw     = MemReady;
        w_pcw     = MemReady;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        w_rw      = w_condex;
        w_pcw     = w_condex & w_rd_pc;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        w_mw   = w_condex;
      end
      EXECR:    ALUControl = w_exec_alu;
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = w_exec_alu;
      end
      ALUWB: begin
        w_rw  = w_alu_wb;
        w_pcw = w_alu_wb & w_rd_pc;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        w_pcw     = w_condex;
      end
      default: ;
    endcase
  end

  // State register and flag register; flags only load at the EXEC edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
      r_flags <= FLAGS_RST;
    end else begin
      r_state <= w_next;
      if ((r_state == EXECR || r_state == EXECI) && w_s && w_condex && w_cmd_def) begin
        r_flags[3:2] <= ALUFlags[3:2];
        if (w_cmd_arith) begin
          r_flags[1:0] <= ALUFlags[1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_multicycle_controller                                      |
// | Brief    : Directed self-checking bench for multicycle_controller.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_multicycle_controller;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] exp;   // {State, PCWrite, IRWrite, RegWrite, MemWrite}
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs mid-cycle, queue the expectation, then compare.
  task automatic step(input string tag, input logic [31:0] instr, input logic [3:0] flags,
                      input logic mr, input logic [3:0] st,
                      input logic pcw, input logic irw, input logic rw, input logic mw);
    exp_t e;
    @(negedge clk);
    Instr    = instr;
    ALUFlags = flags;
    MemReady = mr;
    sb.push_back('{tag, {st, pcw, irw, rw, mw}});
    #1;
    e = sb.pop_front();
    check(e.tag, {24'h0, State, PCWrite, IRWrite, RegWrite, MemWrite}, {24'h0, e.exp});
  endtask

  // Register-form data-processing instruction through FETCH/DECODE/EXECR/ALUWB.
  task automatic dp(input string tag, input logic [31:0] instr, input logic [3:0] flags,
                    input logic [2:0] alu, input logic rw);
    step({tag, "_fetch"},  instr, 4'h0,  1'b1, S_FETCH,  1'b1, 1'b1, 1'b0, 1'b0);
    step({tag, "_decode"}, instr, 4'h0,  1'b1, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0);
    step({tag, "_execr"},  instr, flags, 1'b1, S_EXECR,  1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, "_aluctl"}, {29'h0, ALUControl}, {29'h0, alu});
    step({tag, "_aluwb"},  instr, 4'h0,  1'b1, S_ALUWB,  1'b0, 1'b0, rw,   1'b0);
  endtask

  // Conditional branch used to observe the internal flag register.
  task automatic probe(input string tag, input logic [3:0] cond, input logic taken);
    logic [31:0] bi;
    bi = {cond, 28'hA000002};
    step({tag, "_fetch"},  bi, 4'h0, 1'b1, S_FETCH,  1'b1, 1'b1, 1'b0, 1'b0);
    step({tag, "_decode"}, bi, 4'h0, 1'b1, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0);
    step({tag, "_branch"}, bi, 4'h0, 1'b1, S_BRANCH, taken, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    Instr    = 32'h0;
    ALUFlags = 4'h0;
    MemReady = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("rst_state",   {28'h0, State},   {28'h0, S_FETCH});
    check("rst_strobes", {28'h0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'h0);
    check("rst_srca",    {31'h0, ALUSrcA},   32'h1);
    check("rst_srcb",    {30'h0, ALUSrcB},   32'h2);
    check("rst_res",     {30'h0, ResultSrc}, 32'h2);
    @(negedge clk);
    reset    = 1'b0;
    MemReady = 1'b0;

    // Fetch wait state, then ADD R1,R2,R3 (no S: ALU flags ignored)
    step("fetch_wait", 32'hE0821003, 4'h0, 1'b0, S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0);
    dp("add", 32'hE0821003, 4'hF, 3'b000, 1'b1);

    // LDR R1,[R2] with three memory wait cycles
    step("ldr_fetch",  32'hE5921000, 4'h0, 1'b1, S_FETCH,  1'b1, 1'b1, 1'b0, 1'b0);
    step("ldr_decode", 32'hE5921000, 4'h0, 1'b1, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ldr_immsrc", {30'h0, ImmSrc}, 32'h1);
    check("ldr_regsrc", {30'h0, RegSrc}, 32'h2);
    step("ldr_memadr", 32'hE5921000, 4'h0, 1'b1, S_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ldr_srcb", {30'h0, ALUSrcB}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      step("ldr_wait", 32'hE5921000, 4'h0, 1'b0, S_MEMREAD, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ldr_adrsrc", {31'h0, AdrSrc}, 32'h1);
    end
    step("ldr_memread", 32'hE5921000, 4'h0, 1'b1, S_MEMREAD, 1'b0, 1'b0, 1'b0, 1'b0);
    step("ldr_memwb",   32'hE5921000, 4'h0, 1'b1, S_MEMWB,   1'b0, 1'b0, 1'b1, 1'b0);
    check("ldr_res", {30'h0, ResultSrc}, 32'h1);

    // SUBS sets Z, BEQ taken; STRNE then skipped
    dp("subs_z", 32'hE0521003, 4'b0100, 3'b001, 1'b1);
    probe("beq_taken", 4'h0, 1'b1);
    step("strne_fetch",  32'h15821000, 4'h0, 1'b1, S_FETCH,    1'b1, 1'b1, 1'b0, 1'b0);
    step("strne_decode", 32'h15821000, 4'h0, 1'b1, S_DECODE,   1'b0, 1'b0, 1'b0, 1'b0);
    step("strne_memadr", 32'h15821000, 4'h0, 1'b1, S_MEMADR,   1'b0, 1'b0, 1'b0, 1'b0);
    step("strne_memwr",  32'h15821000, 4'h0, 1'b0, S_MEMWRITE, 1'b0, 1'b0, 1'b0, 1'b0);

    // SUBS clears Z, BEQ not taken
    dp("subs_nz", 32'hE0521003, 4'b0000, 3'b001, 1'b1);
    probe("beq_not", 4'h0, 1'b0);

    // STR (always) with one wait cycle: write strobe held until ready
    step("str_fetch",  32'hE5821000, 4'h0, 1'b1, S_FETCH,    1'b1, 1'b1, 1'b0, 1'b0);
    step("str_decode", 32'hE5821000, 4'h0, 1'b1, S_DECODE,   1'b0, 1'b0, 1'b0, 1'b0);
    step("str_memadr", 32'hE5821000, 4'h0, 1'b1, S_MEMADR,   1'b0, 1'b0, 1'b0, 1'b0);
    step("str_wait",   32'hE5821000, 4'h0, 1'b0, S_MEMWRITE, 1'b0, 1'b0, 1'b0, 1'b1);
    step("str_done",   32'hE5821000, 4'h0, 1'b1, S_MEMWRITE, 1'b0, 1'b0, 1'b0, 1'b1);

    // ANDS: only N,Z load from the ALU; C,V keep 00
    dp("ands", 32'hE0121003, 4'b1011, 3'b010, 1'b1);
    probe("bmi", 4'h4, 1'b1);
    probe("bvs", 4'h6, 1'b0);
    probe("bcs", 4'h2, 1'b0);
    probe("bge", 4'hA, 1'b0);
    probe("bnv", 4'hF, 1'b0);

    // Reset asserted mid-EXECR of an ADDS, with Z set beforehand
    dp("subs_z2", 32'hE0521003, 4'b0100, 3'b001, 1'b1);
    step("adds_fetch",  32'hE0921003, 4'h0, 1'b1, S_FETCH,  1'b1, 1'b1, 1'b0, 1'b0);
    step("adds_decode", 32'hE0921003, 4'h0, 1'b1, S_DECODE, 1'b0, 1'b0, 1'b0, 1'b0);
    step("adds_execr",  32'hE0921003, 4'hF, 1'b1, S_EXECR,  1'b0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("midrst_state",   {28'h0, State}, {28'h0, S_FETCH});
    check("midrst_strobes", {28'h0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'h0);
    @(negedge clk);
    reset    = 1'b0;
    MemReady = 1'b0;
    probe("beq_after_rst", 4'h0, 1'b0);

    // CMP R2,R3 with ALU flags 0110
`ifdef MCCTRL_CMP_EN
    dp("cmp", 32'hE1520003, 4'b0110, 3'b001, 1'b0);
    probe("beq_cmp", 4'h0, 1'b1);
    probe("bcs_cmp", 4'h2, 1'b1);
`else
    dp("cmp", 32'hE1520003, 4'b0110, 3'b000, 1'b0);
    probe("beq_cmp", 4'h0, 1'b0);
    probe("bcs_cmp", 4'h2, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
